fpu_rr_arbiter: RTL
===================

// Module: fpu_rr_arbiter
//
// PURPOSE
//   Round-robin arbiter that shares one FPU operation port between NUM_REQ requesters.
//   - Picks one requester and steers its request word to the FPU through an instance of
//     the generic mux (in = req_data, port = grant index).
//   - Holds exactly one operation in flight and routes the FPU result back to the owner.
//   - Sits between the issue stages and the shared FPU core.
//
// PARAMETERS
//   DATA_SIZE    32   width of request word (opcode+operands) and of result word
//   SELECT_SIZE  2    requester index width; NUM_REQ = 2**SELECT_SIZE requesters
//
// PORTS
//   clk         in   1                       clock, rising edge
//   rst_n       in   1                       asynchronous, active-low reset
//   req_valid   in   NUM_REQ                 per-requester request valid
//   req_data    in   DATA_SIZE x NUM_REQ     unpacked array of request words, index = requester
//   req_ready   out  NUM_REQ                 per-requester accept; at most one bit high
//   fpu_valid   out  1                       request to FPU valid
//   fpu_data    out  DATA_SIZE               request word to FPU (mux output)
//   fpu_ready   in   1                       FPU accepts fpu_data
//   fpu_done    in   1                       FPU result valid, single-cycle pulse
//   fpu_result  in   DATA_SIZE               FPU result word
//   rsp_valid   out  NUM_REQ                 one-cycle result strobe to owning requester
//   rsp_data    out  DATA_SIZE               registered result word, shared by all requesters
//   owner       out  SELECT_SIZE             index of current grant (valid when busy=1)
//   busy        out  1                       state != IDLE
//   err         out  1                       sticky protocol error flag
//
// BEHAVIOUR
//   Reset (rst_n=0, async):
//     - state=IDLE, rr_ptr=0, owner=0.
//     - busy, err, fpu_valid, req_ready, rsp_valid = 0.
//     - rsp_data=0. fpu_data is don't-care (mux output).
//     - An in-flight op is abandoned. Its late fpu_done sets err (WAIT is not active).
//   FSM states: IDLE -> ISSUE -> WAIT -> IDLE.
//   IDLE:
//     - If any req_valid, grant = first set bit scanning rr_ptr, rr_ptr+1, ... (mod NUM_REQ).
//     - Register grant into owner, go to ISSUE.
//     - No req_valid: stay in IDLE.
//   ISSUE:
//     - fpu_valid=1; fpu_data = req_data[owner].
//     - req_ready[owner] = fpu_ready (combinational); all other req_ready bits = 0.
//     - Handshake is fpu_valid & fpu_ready. On handshake, go to WAIT.
//     - Grant is locked until the handshake; other requesters' valids are ignored.
//     - req_valid[owner] dropping before handshake: err<=1, abandon, rr_ptr<=owner+1, go to IDLE.
//   WAIT:
//     - fpu_valid=0.
//     - On fpu_done: rsp_data<=fpu_result; rsp_valid[owner]<=1 for exactly the next cycle.
//     - On fpu_done: rr_ptr<=owner+1 (wraps NUM_REQ-1 -> 0); go to IDLE.
//   fpu_done in IDLE or ISSUE: ignored for data routing; err<=1.
//   Simultaneous events:
//     - The rsp_valid cycle coincides with IDLE, so a new grant may be taken in that same cycle.
//     - A requester may receive rsp_valid and be re-granted in the same cycle
//       (it is lowest priority unless it is the only one).
//   Latency:
//     - req_valid -> fpu_valid: 1 cycle (IDLE arbitration cycle).
//     - fpu_done -> rsp_valid: 1 cycle.
//   Throughput: at most 1 op per (3 + FPU latency) cycles.
//   Fairness: a continuously requesting agent waits at most NUM_REQ-1 ops.
//   err clears only on reset.
//
// TESTING
//   1. Single req: req_valid=4'b0100, data=32'h3F800000, fpu_ready=1.
//      -> fpu_valid at cycle+1, fpu_data=32'h3F800000, req_ready=4'b0100 at handshake.
//      -> fpu_done, fpu_result=32'h40000000 -> rsp_valid=4'b0100, rsp_data=32'h40000000 next cycle.
//   2. All 4 valid continuously, FPU latency 2.
//      -> grant order 0,1,2,3,0; owner wraps 3->0; req_ready one-hot every handshake.
//   3. Backpressure: fpu_ready=0 for 5 cycles in ISSUE.
//      -> fpu_valid and fpu_data held stable, req_ready all 0, no state change.
//   4. Reset in WAIT (rst_n low 1 cycle), then stale fpu_done.
//      -> outputs 0 immediately (async); rsp_valid stays 0; err=1.
//   5. Owner drops req_valid in ISSUE with fpu_ready=0.
//      -> err=1, return to IDLE, next grant is owner+1.
//   6. fpu_done pulsed in IDLE.
//      -> err=1; rsp_valid stays 0.

Source files
------------

// File: rtl/fpu_rr_arbiter.sv
// Round-robin arbiter sharing one FPU operation port between 2**SELECT_SIZE requesters.
// One operation in flight at a time; the result is steered back to the owning requester.

module generic_mux #(
  parameter int DATA_SIZE   = 32,
  parameter int SELECT_SIZE = 2
) (
  input  logic [DATA_SIZE-1:0]   in [2**SELECT_SIZE],
  input  logic [SELECT_SIZE-1:0] port,
  output logic [DATA_SIZE-1:0]   out
);

  assign out = in[port];

endmodule

module fpu_rr_arbiter #(
  parameter int DATA_SIZE   = 32,
  parameter int SELECT_SIZE = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [2**SELECT_SIZE-1:0]  req_valid,
  input  logic [DATA_SIZE-1:0]       req_data [2**SELECT_SIZE],
  output logic [2**SELECT_SIZE-1:0]  req_ready,
  output logic                       fpu_valid,
  output logic [DATA_SIZE-1:0]       fpu_data,
  input  logic                       fpu_ready,
  input  logic                       fpu_done,
  input  logic [DATA_SIZE-1:0]       fpu_result,
  output logic [2**SELECT_SIZE-1:0]  rsp_valid,
  output logic [DATA_SIZE-1:0]       rsp_data,
  output logic [SELECT_SIZE-1:0]     owner,
  output logic                       busy,
  output logic                       err
);

  localparam int NUM_REQ = 2 ** SELECT_SIZE;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [SELECT_SIZE-1:0]   rr_ptr_q, rr_ptr_d;
  logic [SELECT_SIZE-1:0]   owner_q, owner_d;
  logic                     err_q, err_d;
  logic [NUM_REQ-1:0]       rsp_valid_q, rsp_valid_d;
  logic [DATA_SIZE-1:0]     rsp_data_q, rsp_data_d;
  logic                     busy_q, busy_d;
  logic                     fpu_valid_q, fpu_valid_d;

  logic                     grant_found;
  logic [SELECT_SIZE-1:0]   grant_idx;
  logic [SELECT_SIZE-1:0]   cand;

  // Scan from rr_ptr upwards with wrap; the first asserted valid wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = rr_ptr_q;
    cand        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = rr_ptr_q + SELECT_SIZE'(i);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    err_d       = err_q;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      IDLE: begin
        if (fpu_done) err_d = 1'b1;
        if (grant_found) begin
          owner_d = grant_idx;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (fpu_done) err_d = 1'b1;
        // Once the FPU has accepted the word the op is committed, even if the requester lets go.
        if (fpu_ready) begin
          state_d = WAIT;
        end else if (!req_valid[owner_q]) begin
          err_d    = 1'b1;
          rr_ptr_d = owner_q + SELECT_SIZE'(1);
          state_d  = IDLE;
        end
      end
      WAIT: begin
        if (fpu_done) begin
          rsp_data_d           = fpu_result;
          rsp_valid_d[owner_q] = 1'b1;
          rr_ptr_d             = owner_q + SELECT_SIZE'(1);
          state_d              = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d      = (state_d != IDLE);
    fpu_valid_d = (state_d == ISSUE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
      fpu_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      busy_q      <= busy_d;
      fpu_valid_q <= fpu_valid_d;
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == ISSUE && fpu_ready) req_ready[owner_q] = 1'b1;
  end

  generic_mux #(
    .DATA_SIZE   (DATA_SIZE),
    .SELECT_SIZE (SELECT_SIZE)
  ) u_req_mux (
    .in   (req_data),
    .port (owner_q),
    .out  (fpu_data)
  );

  assign fpu_valid = fpu_valid_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign owner     = owner_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule
